// File: rtl/serial_sge.sv
// serial_sge: bit-serial signed greater-than-or-equal comparator.
// Operands are captured on accept, then scanned MSB-first, one bit per cycle.
// The scan stops at the first differing bit, and the result is then held until
// the consumer takes it.
//
// Handshake rules (both sides): a transfer happens on a rising CLK edge where
// valid and ready are both high. in_ready is high only in IDLE. out_valid is
// high only in DONE. Both decode from state alone. While out_valid is high and
// out_ready is low, out holds steady.
module serial_sge #(
  parameter int width = 7
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in0,
  input  logic [width-1:0] in1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out
);

  // The bit index needs at least one bit, even when width is 1.
  localparam int IW = (width > 1) ? $clog2(width) : 1;
  localparam logic [IW-1:0] IDX_MSB = IW'(width - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [width-1:0] a_q, a_d;
  logic [width-1:0] b_q, b_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             res_q, res_d;

  // Bits of the two operands at the current scan position.
  logic bit_a;
  logic bit_b;
  logic at_sign;

  assign bit_a   = a_q[idx_q];
  assign bit_b   = b_q[idx_q];
  assign at_sign = (idx_q == IDX_MSB);

  // State register and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= IDX_MSB;
      res_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
    end
  end

  // Next-state and datapath update: capture on accept, then one bit per SCAN cycle.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = in0;
          b_d     = in1;
          idx_d   = IDX_MSB;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (bit_a != bit_b) begin
          // At the sign bit, the operand with a 0 (the non-negative one) is larger.
          // Below the sign bit, the operand with a 1 is larger.
          res_d   = at_sign ? bit_b : bit_a;
          state_d = S_DONE;
        end else if (idx_q == '0) begin
          res_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decode from registered state only, so there is no input-to-output path.
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    out       = res_q;
  end

endmodule

// File: doc/serial_sge.md
# serial_sge

Multi-cycle signed greater-than-or-equal comparator with valid/ready handshakes on both sides. It is the sequential counterpart of the combinational `coreir_sge` primitive. It accepts an operand pair, scans the bits MSB-first at one bit per cycle, and terminates early at the first differing bit. The block sits where area matters more than latency, or where operands arrive from a handshaked stream and the result feeds a handshaked consumer.

## Interface
Parameters:
- width, default 7, operand width in bits; legal range ≥ 1.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- ASYNCRESETN  input  1  reset, asynchronous and active-low.
- in_valid  input  1  operand pair is valid.
- in_ready  output  1  block can accept an operand pair; high only in IDLE.
- in0  input  width  left operand, two's complement.
- in1  input  width  right operand, two's complement.
- out_valid  output  1  result is valid; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- out  output  1  result: 1 iff $signed(in0) >= $signed(in1).

## Operation
- Registered state:
  - state ∈ {IDLE, SCAN, DONE}
  - a, b: captured operands, width bits each
  - idx: current bit index, clog2(width) bits, minimum 1
  - res: result bit
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: capture a ← in0, b ← in1, set idx ← width-1, go to SCAN.
- SCAN: examine bit idx each cycle.
  - idx == width-1 (sign bit) and a[idx] != b[idx]: res ← b[idx] (a non-negative, b negative gives 1). Go to DONE.
  - idx < width-1 and a[idx] != b[idx]: res ← a[idx]. Go to DONE.
  - Bits equal and idx == 0: res ← 1 (operands equal). Go to DONE.
  - Bits equal and idx > 0: idx ← idx-1. Stay in SCAN.
- DONE:
  - out_valid = 1 and out = res.
  - On out_ready go to IDLE.
  - out is held stable while out_valid && !out_ready.
- in_valid is ignored outside IDLE. Operands are sampled only at the accept edge, so in0/in1 may change freely afterwards.
- No combinational path from in0/in1/in_valid/out_ready to any output. in_ready and out_valid decode from state only.
- out is driven from res in all states. res is only updated on a SCAN decision.
- width = 1: the sign bit is also bit 0. Differ gives res ← b[0]; equal gives res ← 1.

## Timing
- Reset (ASYNCRESETN low, effective immediately):
  - state = IDLE, so in_ready = 1 and out_valid = 0
  - res = 0, so out = 0
  - a = b = 0, idx = width-1
- Reset asserted mid-SCAN or mid-DONE: the operation is abandoned and no result is emitted. After release, the block accepts a new pair on the first edge with in_valid high.
- Let d be the highest index where in0 and in1 differ, and n = width - d. If the operands are equal, n = width.
- Accept on edge E0. SCAN occupies n cycles. out_valid rises after edge E0+n. Latency is n+1 edges from accept to result visible.
- Best case is n = 1 (sign bits differ). Worst case is n = width (equal operands, or a difference only at bit 0).
- Back-to-back operation:
  - DONE with out_ready high returns to IDLE on that edge.
  - The next accept occurs on the following edge at the earliest.
  - Minimum initiation interval is n+2 cycles.
- Simultaneous in_valid while in DONE: not accepted, because in_ready = 0.

## Test plan
- Reset behaviour: drive ASYNCRESETN low asynchronously between edges → in_ready = 1, out_valid = 0, out = 0 immediately. Release, then accept in0 = 5, in1 = 6 → out = 0.
- Early exit on sign (width = 7): in0 = 5 (0000101), in1 = -3 (1111101) → out_valid after 2 edges, out = 1. In the reverse direction, in0 = -64, in1 = 63 → out = 0, also after 2 edges.
- Equal operands: in0 = in1 = -1 → n = 7, out_valid after 8 edges, out = 1. Repeat with in0 = in1 = 0 → out = 1.
- Mid-bit decision: in0 = 6, in1 = 5 (first difference at bit 1) → out_valid after 7 edges, out = 1. Swapped operands → out = 0.
- Backpressure and ignored input:
  - Hold out_ready = 0 for 5 cycles in DONE → out_valid and out remain stable.
  - Toggle in_valid and in0 meanwhile → no capture, in_ready = 0.
  - Raise out_ready → IDLE next edge, in_ready = 1.
- Reset mid-SCAN plus randomized check: assert ASYNCRESETN low during SCAN of in0 = in1 = 0 → no out_valid pulse, state returns to IDLE. Then run 1000 random pairs with random out_ready; every result must match $signed(in0) >= $signed(in1) with the latency given in Timing.
